// File: rtl/mul_hilo_ctrl.sv
// Multiply sequencer: latches signed operands, waits LAT cycles for booth_mul, writes HI/LO.
// Optional macro MUL_OVF_FLAG_EN enables the registered ovf flag; otherwise ovf is tied low.

module booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0] a_ext;
  logic                      prev;

  // Radix-2 Booth recoding: each (b[i], b[i-1]) pair adds, subtracts or skips a<<i
  always_comb begin
    acc   = '0;
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    prev  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({b[i], prev})
        2'b01:   acc = acc + (a_ext <<< i);
        2'b10:   acc = acc - (a_ext <<< i);
        default: acc = acc;
      endcase
      prev = b[i];
    end
    p = acc;
  end

endmodule

module mul_hilo_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] op_a,
  input  logic signed [WIDTH-1:0] op_b,
  input  logic                    hi_wr,
  input  logic                    lo_wr,
  input  logic        [WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic        [WIDTH-1:0] hi,
  output logic        [WIDTH-1:0] lo,
  output logic                    ovf
);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      load;
  logic                      done_d;
  logic                      hi_en, lo_en;
  logic signed [WIDTH-1:0]   opa_q, opb_q;
  logic signed [2*WIDTH-1:0] prod;

  booth_mul #(.WIDTH(WIDTH)) u_booth (
    .a (opa_q),
    .b (opb_q),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) state_d = WRITE;
            else               cnt_d   = cnt_q - 4'd1;
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Direct writes only land in an idle cycle that is not also accepting a multiply
  assign hi_en = (state_q == IDLE) && !start && hi_wr;
  assign lo_en = (state_q == IDLE) && !start && lo_wr;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      opa_q <= '0;
      opb_q <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (load) begin
        opa_q <= op_a;
        opb_q <= op_b;
      end
      if (state_q == WRITE) begin
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end else begin
        if (hi_en) hi <= wr_data;
        if (lo_en) lo <= wr_data;
      end
    end
  end

`ifdef MUL_OVF_FLAG_EN
  // Product overflows when HI is not just the sign extension of LO
  function automatic logic overflows(input logic signed [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                 ovf <= 1'b0;
    else if (state_q == WRITE)  ovf <= overflows(prod);
    else if (hi_en || lo_en)    ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl (WIDTH=32, LAT=2); ovf expectations follow MUL_OVF_FLAG_EN.
module tb_mul_hilo_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = 2;
`ifdef MUL_OVF_FLAG_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    clr_n, start, hi_wr, lo_wr;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic        [WIDTH-1:0] wr_data;
  logic                    busy, done, ovf;
  logic        [WIDTH-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mul_hilo_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns just after the accepting edge
  task automatic issue(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Edges elapsed after the accepting edge until done is seen (bounded)
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int n_done;
    clr_n = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op_a = '0; op_b = '0; wr_data = '0;
    #13;
    n_checks++;
    if ({busy, done, ovf, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b ovf=%b hi=%h lo=%h, required all zero", busy, done, ovf, hi, lo);
    end
    clr_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done !== 0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: activity=%0d hi=%h lo=%h, required 0/0/0", n_done, hi, lo);
    end
  endtask

  task automatic test_basic();
    int nb, cyc;
    issue(32'sd123, 32'sd456);
    nb = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) nb++;
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== LAT + 1 || nb !== LAT + 1) begin
      n_fail++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, required %0d/%0d", cyc, nb, LAT + 1, LAT + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000DB18) begin
      n_fail++;
      $display("FAIL basic_product: busy=%b hi=%h lo=%h, required 0/00000000/0000db18", busy, hi, lo);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_signed();
    int cyc;
    issue(-32'sd444, -32'sd333);
    wait_done(cyc);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'd147852 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_neg: hi=%h lo=%h ovf=%b, required 00000000/%h/0", hi, lo, ovf, 32'd147852);
    end
    issue(32'sh7FFFFFFF, 32'sd2);
    wait_done(cyc);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'hFFFFFFFE || ovf !== OVF_ON) begin
      n_fail++;
      $display("FAIL max_times2: hi=%h lo=%h ovf=%b, required 00000000/fffffffe/%b", hi, lo, ovf, OVF_ON);
    end
    issue(32'sh80000000, 32'sd2);
    wait_done(cyc);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'h0 || ovf !== OVF_ON) begin
      n_fail++;
      $display("FAIL min_times2: hi=%h lo=%h ovf=%b, required ffffffff/00000000/%b", hi, lo, ovf, OVF_ON);
    end
  endtask

  task automatic test_busy_ignore();
    int n_done;
    issue(32'sd5, 32'sd7);
    start = 1'b1; op_a = 32'sd9; op_b = 32'sd9; hi_wr = 1'b1; wr_data = 32'h0000AAAA;
    tick();
    n_checks++;
    if (hi !== 32'hFFFFFFFF || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hi_wr_dropped: hi=%h busy=%b, required ffffffff/1", hi, busy);
    end
    op_a = -32'sd1; op_b = 32'sd100;
    tick();
    start = 1'b0; hi_wr = 1'b0;
    n_done = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done !== 1 || hi !== 32'h0 || lo !== 32'd35) begin
      n_fail++;
      $display("FAIL busy_ignore: done_pulses=%0d hi=%h lo=%h, required 1/00000000/00000023", n_done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    issue(32'sd3, 32'sd4);
    wait_done(c1);
    n_checks++;
    if (c1 !== LAT + 1 || hi !== 32'h0 || lo !== 32'd12) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d hi=%h lo=%h, required %0d/00000000/0000000c", c1, hi, lo, LAT + 1);
    end
    issue(-32'sd2, 32'sd8);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b busy=%b, required 0/1", done, busy);
    end
    wait_done(c2);
    n_checks++;
    if (c2 !== LAT + 1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF0) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d hi=%h lo=%h, required %0d/ffffffff/fffffff0", c2, hi, lo, LAT + 1);
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    issue(32'sd7, 32'sd7);
    tick();
    clr_n = 1'b0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_in_reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    end
    clr_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done !== 0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_after: done_pulses=%0d hi=%h lo=%h, required 0/0/0", n_done, hi, lo);
    end
  endtask

  task automatic test_direct_write();
    int cyc;
    lo_wr = 1'b1; wr_data = 32'h00005555;
    tick();
    lo_wr = 1'b0;
    hi_wr = 1'b1; wr_data = 32'h00001234;
    tick();
    hi_wr = 1'b0;
    n_checks++;
    if (hi !== 32'h00001234 || lo !== 32'h00005555) begin
      n_fail++;
      $display("FAIL mthi: hi=%h lo=%h, required 00001234/00005555", hi, lo);
    end
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h0000BEEF;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    n_checks++;
    if (hi !== 32'h0000BEEF || lo !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL both_wr: hi=%h lo=%h, required 0000beef/0000beef", hi, lo);
    end
    issue(32'sh7FFFFFFF, 32'sd2);
    wait_done(cyc);
    lo_wr = 1'b1; wr_data = 32'h00000007;
    tick();
    lo_wr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0 || lo !== 32'h7 || hi !== 32'h0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b hi=%h lo=%h, required 0/00000000/00000007", ovf, hi, lo);
    end
    hi_wr = 1'b1; wr_data = 32'h0000DEAD;
    issue(32'sd2, 32'sd3);
    hi_wr = 1'b0;
    n_checks++;
    if (hi !== 32'h0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_priority: hi=%h busy=%b, required 00000000/1", hi, busy);
    end
    wait_done(cyc);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      n_fail++;
      $display("FAIL start_priority_product: hi=%h lo=%h, required 00000000/00000006", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_direct_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
